// File: rtl/ds1302_timemod.sv
// Time-keeping front end for a DS1302 base module: clears write-protect after reset,
// polls sec/min/hour periodically and publishes them, and writes a new time on request.
module ds1302_timemod #(
  parameter int POLL_CYCLES = 5_000_000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iSet,
  input  logic [7:0] iHour,
  input  logic [7:0] iMin,
  input  logic [7:0] iSec,
  output logic [7:0] oCall,
  input  logic       iDone,
  output logic [7:0] oData,
  input  logic [7:0] iData,
  output logic [7:0] oHour,
  output logic [7:0] oMin,
  output logic [7:0] oSec,
  output logic       oHalt,
  output logic       oValid,
  output logic       oBusy
);

  typedef enum logic [3:0] {
    INIT, IDLE, RD_SEC, RD_MIN, RD_HOUR, PUB,
    WR_CTRL, WR_HOUR, WR_MIN, WR_SEC, GAP
  } state_t;

  localparam logic [31:0] LAST_TICK = 32'(POLL_CYCLES - 1);

  state_t      state, stateNext;
  state_t      retState, retNext;
  logic [7:0]  callNext, dataNext;
  logic [31:0] timer;
  logic        pending;
  logic        expired;
  logic        cmdDone;
  logic [6:0]  latHour, latMin, latSec;
  logic [6:0]  shSec, shHour;
  logic [7:0]  shMin;
  logic        shHalt;
  logic        unusedBits;

  // The time fields are 7-bit BCD; bit 7 of each set input is never written.
  assign unusedBits = ^{iHour[7], iMin[7], iSec[7]};

  function automatic logic [7:0] cmdCode(input state_t s);
    case (s)
      INIT, WR_CTRL: cmdCode = 8'h80;
      WR_HOUR:       cmdCode = 8'h40;
      WR_MIN:        cmdCode = 8'h20;
      WR_SEC:        cmdCode = 8'h10;
      RD_HOUR:       cmdCode = 8'h04;
      RD_MIN:        cmdCode = 8'h02;
      RD_SEC:        cmdCode = 8'h01;
      default:       cmdCode = 8'h00;
    endcase
  endfunction

  function automatic state_t afterCmd(input state_t s);
    case (s)
      RD_SEC:  afterCmd = RD_MIN;
      RD_MIN:  afterCmd = RD_HOUR;
      RD_HOUR: afterCmd = PUB;
      WR_CTRL: afterCmd = WR_HOUR;
      WR_HOUR: afterCmd = WR_MIN;
      WR_MIN:  afterCmd = WR_SEC;
      default: afterCmd = IDLE;
    endcase
  endfunction

  assign expired = (timer == LAST_TICK);
  // A completion pulse only counts while a command is actually on the bus.
  assign cmdDone = (oCall != 8'h00) && iDone;
  assign oBusy   = !((state == IDLE) && !pending);

  always_comb begin
    stateNext = state;
    retNext   = retState;
    callNext  = oCall;
    dataNext  = oData;
    case (state)
      IDLE: begin
        if (pending || iSet) stateNext = WR_CTRL;
        else if (expired)    stateNext = RD_SEC;
      end
      PUB: stateNext = IDLE;
      GAP: stateNext = retState;
      default: begin
        // Command states: first cycle issues the call, then wait for completion.
        if (oCall == 8'h00) begin
          callNext = cmdCode(state);
          case (state)
            WR_HOUR: dataNext = {1'b0, latHour};
            WR_MIN:  dataNext = {1'b0, latMin};
            WR_SEC:  dataNext = {1'b0, latSec};
            default: dataNext = 8'h00;
          endcase
        end else if (iDone) begin
          callNext  = 8'h00;
          dataNext  = 8'h00;
          stateNext = GAP;
          retNext   = afterCmd(state);
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= INIT;
      retState <= IDLE;
      oCall    <= 8'h00;
      oData    <= 8'h00;
      timer    <= 32'd0;
      pending  <= 1'b0;
      oHour    <= 8'h00;
      oMin     <= 8'h00;
      oSec     <= 8'h00;
      oHalt    <= 1'b0;
      oValid   <= 1'b0;
    end else begin
      state    <= stateNext;
      retState <= retNext;
      oCall    <= callNext;
      oData    <= dataNext;
      timer    <= ((state == IDLE) && (stateNext == IDLE)) ? timer + 32'd1 : 32'd0;
      if ((state == IDLE) && (stateNext == WR_CTRL)) pending <= 1'b0;
      else if (iSet)                                 pending <= 1'b1;
      // Publish on the edge that enters PUB so oValid and the new time coincide.
      oValid <= (state == GAP) && (retState == PUB);
      if ((state == GAP) && (retState == PUB)) begin
        oSec  <= {1'b0, shSec};
        oMin  <= shMin;
        oHour <= {1'b0, shHour};
        oHalt <= shHalt;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (iSet) begin
      latHour <= iHour[6:0];
      latMin  <= iMin[6:0];
      latSec  <= iSec[6:0];
    end
    if (cmdDone) begin
      case (state)
        RD_SEC: begin
          shSec  <= iData[6:0];
          shHalt <= iData[7];
        end
        RD_MIN:  shMin  <= iData;
        RD_HOUR: shHour <= iData[6:0];
        default: ;
      endcase
    end
  end

endmodule
